seg_display_ctrl: RTL and testbench

- Consumer side of the switch-decoded display control interface: takes display_op[2:0] and ram_display_addr and shows the selected 32-bit value as 8 hex digits.
- Drives a time-multiplexed 8-digit seven-segment display with active-low segments and anodes.
- Reads data memory through a synchronous read port and snapshots the selected value once per refresh frame, so a digit never tears mid-frame.
- Runs on the board clock, not the divided CPU clock.

---
 rtl/seg_display_ctrl_pkg.sv | 26 ++
 rtl/seg_display_ctrl_hex7seg.sv | 30 +++
 rtl/seg_display_ctrl.sv | 119 +++++++++++
 tb/tb_seg_display_ctrl.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/seg_display_ctrl_pkg.sv
// Shared encodings for the seven-segment display controller.
package seg_display_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 8;

    // Source selected by the switch-decoded display_op field.
    typedef enum logic [2:0] {
        OP_RAM     = 3'b000,
        OP_PC      = 3'b001,
        OP_TOTAL   = 3'b010,
        OP_JUMP    = 3'b011,
        OP_BRANCH  = 3'b100,
        OP_TAKEN   = 3'b101,
        OP_SYSCALL = 3'b110,
        OP_DBG     = 3'b111
    } display_op_t;

    // Once-per-frame snapshot sequencer.
    typedef enum logic [1:0] {
        SCAN,
        REQ,
        WAIT,
        LATCH
    } snap_state_t;

endpackage

// File: rtl/seg_display_ctrl_hex7seg.sv
// Hex nibble to active-low seven-segment glyph {dp,g,f,e,d,c,b,a}; dp always off.
module hex7seg (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    // Glyph lookup table.
    always_comb begin
        seg = 8'hFF;
        unique case (nibble)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
        endcase
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// Time-multiplexed 8-digit hex display with a per-frame snapshot of the
// selected 32-bit source, so digits never mix old and new values mid-frame.
module seg_display_ctrl
    import seg_display_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BITS = 12,
    parameter int unsigned SCAN_DIV  = 100_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           display_op,
    input  logic [ADDR_BITS-3:0] ram_display_addr,
    output logic [ADDR_BITS-3:0] ram_rd_addr,
    input  logic [31:0]          ram_rd_data,
    input  logic [31:0]          pc,
    input  logic [31:0]          cnt_total,
    input  logic [31:0]          cnt_jump,
    input  logic [31:0]          cnt_branch,
    input  logic [31:0]          cnt_taken,
    input  logic [31:0]          syscall_out,
    output logic [7:0]           seg,
    output logic [7:0]           an,
    output logic                 snap_strobe
);

    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DIGIT_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]   scan_cnt;
    logic [DIGIT_W-1:0] digit;
    logic               tc;
    logic [31:0]        shadow;
    logic [31:0]        sel;
    logic [15:0]        addr16;
    logic [7:0]         glyph;
    display_op_t        op_q;
    snap_state_t        state;

    assign tc     = (scan_cnt == CNT_W'(SCAN_DIV - 1));
    assign addr16 = 16'(ram_rd_addr);

    // Digit slot timer and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            digit    <= '0;
        end else if (tc) begin
            scan_cnt <= '0;
            digit    <= digit + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    hex7seg u_hex7seg (
        .nibble (shadow[{digit, 2'b00} +: 4]),
        .seg    (glyph)
    );

    // Registered segment and anode drive for the current digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= 8'hFF;
            an  <= 8'hFF;
        end else begin
            seg <= glyph;
            an  <= ~(8'b1 << digit);
        end
    end

    // Source mux, keyed by the op captured at the frame boundary.
    always_comb begin
        sel = '0;
        unique case (op_q)
            OP_RAM:     sel = ram_rd_data;
            OP_PC:      sel = pc;
            OP_TOTAL:   sel = cnt_total;
            OP_JUMP:    sel = cnt_jump;
            OP_BRANCH:  sel = cnt_branch;
            OP_TAKEN:   sel = cnt_taken;
            OP_SYSCALL: sel = syscall_out;
            OP_DBG:     sel = {13'b0, op_q, addr16};
        endcase
    end

    // Snapshot sequencer: request RAM at frame end, latch two clks later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= SCAN;
            op_q        <= OP_RAM;
            ram_rd_addr <= '0;
            shadow      <= '0;
            snap_strobe <= 1'b0;
        end else begin
            snap_strobe <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (tc && digit == DIGIT_W'(NUM_DIGITS - 1)) begin
                        state <= REQ;
                    end
                end
                REQ: begin
                    op_q        <= display_op_t'(display_op);
                    ram_rd_addr <= ram_display_addr;
                    state       <= WAIT;
                end
                WAIT: begin
                    state <= LATCH;
                end
                LATCH: begin
                    shadow      <= sel;
                    snap_strobe <= 1'b1;
                    state       <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl with SCAN_DIV=4 (32-clk frames).
module tb_seg_display_ctrl;

    localparam int unsigned ADDR_BITS = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [2:0]           display_op = 3'b001;
    logic [ADDR_BITS-3:0] ram_display_addr = '0;
    logic [ADDR_BITS-3:0] ram_rd_addr;
    logic [31:0]          ram_rd_data = '0;
    logic [31:0]          pc          = 32'h0040_1A3C;
    logic [31:0]          cnt_total   = 32'h0123_4567;
    logic [31:0]          cnt_jump    = 32'h89AB_CDEF;
    logic [31:0]          cnt_branch  = 32'h1111_2222;
    logic [31:0]          cnt_taken   = 32'h3333_4444;
    logic [31:0]          syscall_out = 32'h5555_6666;
    logic [7:0]           seg;
    logic [7:0]           an;
    logic                 snap_strobe;

    int checks   = 0;
    int failures = 0;

    seg_display_ctrl #(
        .ADDR_BITS (ADDR_BITS),
        .SCAN_DIV  (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .display_op       (display_op),
        .ram_display_addr (ram_display_addr),
        .ram_rd_addr      (ram_rd_addr),
        .ram_rd_data      (ram_rd_data),
        .pc               (pc),
        .cnt_total        (cnt_total),
        .cnt_jump         (cnt_jump),
        .cnt_branch       (cnt_branch),
        .cnt_taken        (cnt_taken),
        .syscall_out      (syscall_out),
        .seg              (seg),
        .an               (an),
        .snap_strobe      (snap_strobe)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model: word 5 holds DEADBEEF.
    always @(posedge clk) begin
        ram_rd_data <= (ram_rd_addr == 10'd5) ? 32'hDEAD_BEEF : {22'h0, ram_rd_addr} ^ 32'hA5A5_0000;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns at the negedge where snap_strobe is seen high.
    task automatic wait_strobe(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!snap_strobe && cyc < 100);
        check("strobe_seen", {31'b0, snap_strobe}, 32'd1);
    endtask

    task automatic wait_an(input logic [7:0] target);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== target && n < 100);
        check("an_reach", {24'b0, an}, {24'b0, target});
    endtask

    // Samples 30 clks right after a strobe; the last sample per digit is
    // what the new shadow shows. exp is packed {digit7 .. digit0}.
    task automatic capture(input string name, input logic [63:0] exp);
        logic [7:0] cap [8];
        int strobes = 0;
        for (int unsigned k = 0; k < 8; k++) cap[k] = 8'h00;
        for (int unsigned c = 0; c < 30; c++) begin
            @(negedge clk);
            if (snap_strobe) strobes++;
            for (int unsigned k = 0; k < 8; k++) begin
                if (an == ~(8'b1 << k)) cap[k] = seg;
            end
        end
        check({name, "_quiet"}, strobes, 0);
        for (int unsigned k = 0; k < 8; k++) begin
            check($sformatf("%s_d%0d", name, k), {24'b0, cap[k]}, {24'b0, exp[8*k +: 8]});
        end
    endtask

    initial begin
        int n;
        int cyc;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-run.
        #2 rst = 1'b1;
        #1;
        check("rst_seg", {24'b0, seg}, 32'h0000_00FF);
        check("rst_an", {24'b0, an}, 32'h0000_00FF);
        check("rst_strobe", {31'b0, snap_strobe}, 32'd0);
        check("rst_addr", {22'b0, ram_rd_addr}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // First frame: anode walk, blank zeros, first snapshot 35 clks in.
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n <= 32 && (n % 4) == 1) begin
                check($sformatf("walk_an%0d", (n - 1) / 4), {24'b0, an}, {24'b0, ~(8'b1 << ((n - 1) / 4))});
                check($sformatf("walk_seg%0d", (n - 1) / 4), {24'b0, seg}, 32'h0000_00C0);
            end
        end while (!snap_strobe && n < 60);
        check("first_snap_cycle", n, 35);

        capture("pc", 64'hC0C0_99C0_F988_B0C6);
        wait_strobe(cyc);
        check("strobe_gap1", cyc, 2);

        // Switch source during digit 3; digit 5 still shows the PC.
        wait_an(8'hF7);
        display_op = 3'b010;
        wait_an(8'hDF);
        @(negedge clk);
        check("midframe_d5", {24'b0, seg}, 32'h0000_0099);
        wait_strobe(cyc);
        capture("total", 64'hC0F9_A4B0_9992_82F8);

        // Change while in WAIT: this snapshot keeps the op captured in REQ.
        display_op = 3'b011;
        wait_strobe(cyc);
        check("strobe_gap2", cyc, 2);
        capture("total_hold", 64'hC0F9_A4B0_9992_82F8);
        wait_strobe(cyc);
        capture("jump", 64'h8090_8883_C6A1_868E);

        // RAM word 5.
        display_op       = 3'b000;
        ram_display_addr = 10'h005;
        wait_strobe(cyc);
        wait_strobe(cyc);
        check("ram_addr", {22'b0, ram_rd_addr}, 32'd5);
        capture("ram", 64'hA186_88A1_8386_868E);

        // Debug view of op and address.
        display_op       = 3'b111;
        ram_display_addr = 10'h3FF;
        wait_strobe(cyc);
        wait_strobe(cyc);
        capture("dbg", 64'hC0C0_C0F8_C0B0_8E8E);
        check("dbg_addr_hold", {22'b0, ram_rd_addr}, 32'h0000_03FF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
